// File: rtl/gemm_pkg.sv
// gemm_pkg: shared types and constants for the GEMM accumulator writeback path.
//   wb_state_t          : writeback controller state (IDLE, RUN, DRAIN)
//   GEMM_* localparams  : default lane counts and widths used when slicing rows
//                         into lanes and sizing the accumulator memory
//   GEMM_LANE_GUARD     : extra bits carried on a lane sum to detect overflow
package gemm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } wb_state_t;

  localparam int GEMM_ARRAY_N        = 8;
  localparam int GEMM_PE_OUT_WIDTH   = 19;
  localparam int GEMM_ACC_DATA_WIDTH = 32;
  localparam int GEMM_ACC_ADDR_WIDTH = 12;
  localparam int GEMM_LANE_GUARD     = 1;

endpackage

// File: rtl/acc_writeback_if.sv
// acc_writeback_if: accumulator memory bus between the writeback block and the
// accumulator RAM (one read port with 1-cycle latency, one write port).
//   acc_mem_read_ADDR/EN   : read request, data returns on acc_mem_read_DOUT next cycle
//   acc_mem_write_ADDR/EN/WE/DIN : write request, committed at the clock edge
// modport master: the writeback block; modport slave: the RAM.
interface acc_writeback_if #(
  parameter int ARRAY_N              = 8,
  parameter int ACC_DATA_WIDTH       = 32,
  parameter int ACC_MEM_ADDR_WIDTH_W = 12
);

  logic [ACC_MEM_ADDR_WIDTH_W-1:0]   acc_mem_read_ADDR;
  logic                              acc_mem_read_EN;
  logic [ARRAY_N*ACC_DATA_WIDTH-1:0] acc_mem_read_DOUT;
  logic [ACC_MEM_ADDR_WIDTH_W-1:0]   acc_mem_write_ADDR;
  logic                              acc_mem_write_EN;
  logic                              acc_mem_write_WE;
  logic [ARRAY_N*ACC_DATA_WIDTH-1:0] acc_mem_write_DIN;

  modport master (
    output acc_mem_read_ADDR, acc_mem_read_EN,
    input  acc_mem_read_DOUT,
    output acc_mem_write_ADDR, acc_mem_write_EN, acc_mem_write_WE, acc_mem_write_DIN
  );

  modport slave (
    input  acc_mem_read_ADDR, acc_mem_read_EN,
    output acc_mem_read_DOUT,
    input  acc_mem_write_ADDR, acc_mem_write_EN, acc_mem_write_WE, acc_mem_write_DIN
  );

endinterface

// File: rtl/acc_writeback_lane.sv
// acc_lane_add: one accumulator lane. Sign-extends a PE column result to the
// accumulator width and adds the existing accumulator value when accumulate=1.
//   pe_lane    : signed PE result (PE_OUT_WIDTH)
//   acc_lane   : current accumulator contents (ACC_DATA_WIDTH)
//   accumulate : 1 = pe + acc, 0 = pe alone
//   sum        : lane result (ACC_DATA_WIDTH)
// Build option ACC_WB_SATURATE_EN: clamp to signed min/max instead of wrapping.
module acc_lane_add
  import gemm_pkg::*;
#(
  parameter int PE_OUT_WIDTH   = GEMM_PE_OUT_WIDTH,
  parameter int ACC_DATA_WIDTH = GEMM_ACC_DATA_WIDTH
) (
  input  logic [PE_OUT_WIDTH-1:0]   pe_lane,
  input  logic [ACC_DATA_WIDTH-1:0] acc_lane,
  input  logic                      accumulate,
  output logic [ACC_DATA_WIDTH-1:0] sum
);

`ifdef ACC_WB_SATURATE_EN
  // One guard bit: the top two bits disagree exactly when the signed sum overflowed.
  localparam int SW = ACC_DATA_WIDTH + GEMM_LANE_GUARD;
  logic [SW-1:0] pe_ext;
  logic [SW-1:0] acc_ext;
  logic [SW-1:0] sum_wide;

  always_comb begin
    pe_ext   = {{(SW-PE_OUT_WIDTH){pe_lane[PE_OUT_WIDTH-1]}}, pe_lane};
    acc_ext  = accumulate ? {{GEMM_LANE_GUARD{acc_lane[ACC_DATA_WIDTH-1]}}, acc_lane} : '0;
    sum_wide = pe_ext + acc_ext;
    if (sum_wide[SW-1] != sum_wide[SW-2]) begin
      sum = sum_wide[SW-1] ? {1'b1, {(ACC_DATA_WIDTH-1){1'b0}}}
                           : {1'b0, {(ACC_DATA_WIDTH-1){1'b1}}};
    end else begin
      sum = sum_wide[ACC_DATA_WIDTH-1:0];
    end
  end
`else
  logic [ACC_DATA_WIDTH-1:0] pe_ext;
  logic [ACC_DATA_WIDTH-1:0] acc_ext;

  always_comb begin
    pe_ext  = {{(ACC_DATA_WIDTH-PE_OUT_WIDTH){pe_lane[PE_OUT_WIDTH-1]}}, pe_lane};
    acc_ext = accumulate ? acc_lane : '0;
    sum     = pe_ext + acc_ext;
  end
`endif

endmodule

// File: rtl/acc_writeback.sv
// acc_writeback: writes de-skewed systolic array rows into accumulator memory,
// optionally adding to the rows already stored there.
//   clk, reset_n       : clock, synchronous active-low reset
//   start, base_addr, num_rows, accumulate : job setup, sampled in IDLE
//   pe_out_valid, pe_out_data : one row per cycle, lane i at [i*PE_OUT_WIDTH +: PE_OUT_WIDTH]
//   acc_mem            : accumulator memory bus (acc_writeback_if.master)
//   busy, done, err    : job in flight, end-of-job pulse, sticky dropped-row flag
//   state_dbg          : current controller state
// Build option ACC_WB_SATURATE_EN: lane sums saturate instead of wrapping.
//
// Handshake: pe_out_valid has no ready. A row is accepted in any cycle where
// pe_out_valid=1 and the controller is in RUN; rows offered in IDLE or DRAIN
// are dropped and raise err. There is no backpressure anywhere: the pipeline
// advances every cycle, read at t+1, RAM data at t+2, write at t+3.
module acc_writeback
  import gemm_pkg::*;
#(
  parameter int ARRAY_N              = GEMM_ARRAY_N,
  parameter int PE_OUT_WIDTH         = GEMM_PE_OUT_WIDTH,
  parameter int ACC_DATA_WIDTH       = GEMM_ACC_DATA_WIDTH,
  parameter int ACC_MEM_ADDR_WIDTH_W = GEMM_ACC_ADDR_WIDTH
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              start,
  input  logic [ACC_MEM_ADDR_WIDTH_W-1:0]   base_addr,
  input  logic [ACC_MEM_ADDR_WIDTH_W:0]     num_rows,
  input  logic                              accumulate,
  input  logic                              pe_out_valid,
  input  logic [ARRAY_N*PE_OUT_WIDTH-1:0]   pe_out_data,
  acc_writeback_if.master                   acc_mem,
  output logic                              busy,
  output logic                              done,
  output logic                              err,
  output wb_state_t                         state_dbg
);

  localparam int AW = ACC_MEM_ADDR_WIDTH_W;
  localparam int RP = ARRAY_N * PE_OUT_WIDTH;
  localparam int RA = ARRAY_N * ACC_DATA_WIDTH;

  wb_state_t       state;
  logic [AW-1:0]   addr_ptr;
  logic [AW:0]     rows_q;
  logic [AW:0]     row_cnt;
  logic [AW:0]     row_cnt_nxt;
  logic            acc_q;
  logic            accept;
  logic            last_row;

  // Stage 1 drives the read port, stage 2 meets the RAM data, stage 3 drives
  // the write port. Address/data fields are zeroed whenever the slot is empty
  // so the bus idles at all-zero.
  logic            s1_valid, s1_rd_en, s1_last;
  logic [AW-1:0]   s1_addr;
  logic [RP-1:0]   s1_pe;
  logic            s2_valid, s2_acc, s2_last;
  logic [AW-1:0]   s2_addr;
  logic [RP-1:0]   s2_pe;
  logic            s3_valid, s3_last;
  logic [AW-1:0]   s3_addr;
  logic [RA-1:0]   s3_din;
  logic [RA-1:0]   lane_sum;

  assign accept      = (state == ST_RUN) && pe_out_valid;
  assign row_cnt_nxt = row_cnt + {{AW{1'b0}}, 1'b1};
  assign last_row    = (row_cnt_nxt == rows_q);

  for (genvar i = 0; i < ARRAY_N; i++) begin : g_lane
    acc_lane_add #(
      .PE_OUT_WIDTH   (PE_OUT_WIDTH),
      .ACC_DATA_WIDTH (ACC_DATA_WIDTH)
    ) u_lane (
      .pe_lane    (s2_pe[i*PE_OUT_WIDTH +: PE_OUT_WIDTH]),
      .acc_lane   (acc_mem.acc_mem_read_DOUT[i*ACC_DATA_WIDTH +: ACC_DATA_WIDTH]),
      .accumulate (s2_acc),
      .sum        (lane_sum[i*ACC_DATA_WIDTH +: ACC_DATA_WIDTH])
    );
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      addr_ptr <= '0;
      rows_q   <= '0;
      row_cnt  <= '0;
      acc_q    <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      s1_valid <= 1'b0;
      s1_rd_en <= 1'b0;
      s1_last  <= 1'b0;
      s1_addr  <= '0;
      s1_pe    <= '0;
      s2_valid <= 1'b0;
      s2_acc   <= 1'b0;
      s2_last  <= 1'b0;
      s2_addr  <= '0;
      s2_pe    <= '0;
      s3_valid <= 1'b0;
      s3_last  <= 1'b0;
      s3_addr  <= '0;
      s3_din   <= '0;
    end else begin
      done <= 1'b0;

      s1_valid <= accept;
      s1_rd_en <= accept & acc_q;
      s1_last  <= accept & last_row;
      s1_addr  <= accept ? addr_ptr : '0;
      s1_pe    <= accept ? pe_out_data : '0;

      s2_valid <= s1_valid;
      s2_acc   <= s1_rd_en;
      s2_last  <= s1_last;
      s2_addr  <= s1_addr;
      s2_pe    <= s1_pe;

      s3_valid <= s2_valid;
      s3_last  <= s2_last;
      s3_addr  <= s2_addr;
      s3_din   <= s2_valid ? lane_sum : '0;

      if (s3_valid && s3_last) begin
        done <= 1'b1;
      end

      if (pe_out_valid && (state != ST_RUN)) begin
        err <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (start) begin
            if (num_rows == '0) begin
              done <= 1'b1;
            end else begin
              // A real job clears a previous protocol error.
              err      <= 1'b0;
              state    <= ST_RUN;
              addr_ptr <= base_addr;
              rows_q   <= num_rows;
              acc_q    <= accumulate;
              row_cnt  <= '0;
            end
          end
        end
        ST_RUN: begin
          if (accept) begin
            // Address wraps naturally at 2^AW.
            addr_ptr <= addr_ptr + {{(AW-1){1'b0}}, 1'b1};
            row_cnt  <= row_cnt_nxt;
            if (last_row) begin
              state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (s3_valid && s3_last) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign acc_mem.acc_mem_read_EN    = s1_rd_en;
  assign acc_mem.acc_mem_read_ADDR  = s1_addr;
  assign acc_mem.acc_mem_write_EN   = s3_valid;
  assign acc_mem.acc_mem_write_WE   = s3_valid;
  assign acc_mem.acc_mem_write_ADDR = s3_addr;
  assign acc_mem.acc_mem_write_DIN  = s3_din;

  assign busy      = (state != ST_IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_acc_writeback.sv
// tb_acc_writeback: directed bench for acc_writeback. Drivers push expected
// memory writes, reads and done pulses (with their cycle numbers) into queues;
// a monitor on the falling edge pops and compares whatever the DUT presents.
`timescale 1ns/1ps
module tb_acc_writeback;
  import gemm_pkg::*;

  localparam int N  = 8;
  localparam int PW = 19;
  localparam int DW = 32;
  localparam int AW = 12;
  localparam int RP = N * PW;
  localparam int RW = N * DW;
  localparam int EW = 32 + AW + RW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic            start = 1'b0;
  logic [AW-1:0]   base_addr = '0;
  logic [AW:0]     num_rows = '0;
  logic            accumulate = 1'b0;
  logic            pe_out_valid = 1'b0;
  logic [RP-1:0]   pe_out_data = '0;
  logic            busy, done, err;
  wb_state_t       state_dbg;

  acc_writeback_if #(.ARRAY_N(N), .ACC_DATA_WIDTH(DW), .ACC_MEM_ADDR_WIDTH_W(AW)) mem_if ();

  acc_writeback #(
    .ARRAY_N(N), .PE_OUT_WIDTH(PW), .ACC_DATA_WIDTH(DW), .ACC_MEM_ADDR_WIDTH_W(AW)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .base_addr    (base_addr),
    .num_rows     (num_rows),
    .accumulate   (accumulate),
    .pe_out_valid (pe_out_valid),
    .pe_out_data  (pe_out_data),
    .acc_mem      (mem_if),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .state_dbg    (state_dbg)
  );

  // Accumulator RAM model: 1-cycle read latency, contents preloaded by the bench.
  logic [RW-1:0] ram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_if.acc_mem_read_EN) mem_if.acc_mem_read_DOUT <= ram[mem_if.acc_mem_read_ADDR];
  end

  // ---------------- scoreboard ----------------
  logic [EW-1:0]   exp_q[$];      // {cycle, addr, din} of expected writes
  logic [32+AW-1:0] exp_rd_q[$];  // {cycle, addr} of expected reads
  int              exp_done_q[$];
  int              n_cmp = 0;
  int              n_err = 0;

  task automatic chk(input string name, input logic [RW-1:0] got, input logic [RW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h cycle=%0d", name, got, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s got=unexpected exp=none cycle=%0d", name, cyc);
  endtask

  always @(negedge clk) begin
    logic [EW-1:0] e;
    logic [32+AW-1:0] r;
    if (mem_if.acc_mem_write_EN) begin
      if (exp_q.size() == 0) flag("wr_unexpected");
      else begin
        e = exp_q.pop_front();
        chk("wr_cycle", RW'(cyc), RW'(e[EW-1 -: 32]));
        chk("wr_addr", RW'(mem_if.acc_mem_write_ADDR), RW'(e[RW +: AW]));
        chk("wr_din", mem_if.acc_mem_write_DIN, e[RW-1:0]);
        chk("wr_we", RW'(mem_if.acc_mem_write_WE), RW'(1'b1));
      end
    end else begin
      chk("wr_idle_bus", RW'({mem_if.acc_mem_write_WE, mem_if.acc_mem_write_ADDR}) | mem_if.acc_mem_write_DIN, '0);
    end
    if (mem_if.acc_mem_read_EN) begin
      if (exp_rd_q.size() == 0) flag("rd_unexpected");
      else begin
        r = exp_rd_q.pop_front();
        chk("rd_cycle", RW'(cyc), RW'(r[32+AW-1 -: 32]));
        chk("rd_addr", RW'(mem_if.acc_mem_read_ADDR), RW'(r[AW-1:0]));
      end
    end
    if (done) begin
      if (exp_done_q.size() == 0) flag("done_unexpected");
      else chk("done_cycle", RW'(cyc), RW'(exp_done_q.pop_front()));
    end
  end

  // ---------------- drivers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [RP-1:0] pe_fill(input int v);
    logic [RP-1:0] r;
    for (int i = 0; i < N; i++) r[i*PW +: PW] = PW'(v);
    return r;
  endfunction

  function automatic logic [RW-1:0] acc_fill(input int v);
    logic [RW-1:0] r;
    for (int i = 0; i < N; i++) r[i*DW +: DW] = v;
    return r;
  endfunction

  task automatic start_job(input logic [AW-1:0] b, input logic [AW:0] n, input logic a);
    start = 1'b1; base_addr = b; num_rows = n; accumulate = a;
    if (n == '0) exp_done_q.push_back(cyc + 1);
    step();
    start = 1'b0;
  endtask

  // Row offered in this cycle t: read at t+1 (if accumulating), write at t+3, done at t+4.
  task automatic send_row(input logic [RP-1:0] d, input logic [AW-1:0] a,
                          input logic [RW-1:0] exp_din, input logic rd, input logic last);
    pe_out_valid = 1'b1;
    pe_out_data  = d;
    exp_q.push_back({32'(cyc + 3), a, exp_din});
    if (rd) exp_rd_q.push_back({32'(cyc + 1), a});
    if (last) exp_done_q.push_back(cyc + 4);
    step();
    pe_out_valid = 1'b0;
    pe_out_data  = '0;
  endtask

  task automatic drain();
    int k = 0;
    while ((exp_q.size() != 0 || exp_rd_q.size() != 0 || exp_done_q.size() != 0) && k < 40) begin
      step();
      k++;
    end
    if (k >= 40) flag("drain_timeout");
    step();
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [RP-1:0] d;
    logic [RW-1:0] e;
    logic [RW-1:0] m;
    logic [AW-1:0] wrap_addr [4];
    wrap_addr = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};

    for (int i = 0; i < (1 << AW); i++) ram[i] = '0;
    ram[12'h020] = acc_fill(100);
    ram[12'h021] = acc_fill(100);

    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    chk("rst_busy", RW'(busy), '0);
    chk("rst_done", RW'(done), '0);
    chk("rst_err", RW'(err), '0);
    chk("rst_state", RW'(state_dbg), RW'(ST_IDLE));
    chk("rst_rd_en", RW'(mem_if.acc_mem_read_EN), '0);
    step();

    // Overwrite job: 4 back-to-back rows, lanes k+1, at 0x010..0x013.
    start_job(12'h010, 13'd4, 1'b0);
    chk("busy_run", RW'(busy), RW'(1'b1));
    for (int k = 0; k < 4; k++)
      send_row(pe_fill(k + 1), 12'h010 + AW'(k), acc_fill(k + 1), 1'b0, k == 3);
    chk("state_drain", RW'(state_dbg), RW'(ST_DRAIN));
    drain();
    chk("busy_idle", RW'(busy), '0);

    // Accumulate job: 100 + (-3) = 97, with an ignored start and a gap between rows.
    start_job(12'h020, 13'd2, 1'b1);
    start = 1'b1; base_addr = 12'h500; num_rows = 13'd1; accumulate = 1'b0;
    step();
    start = 1'b0;
    send_row(pe_fill(-3), 12'h020, acc_fill(97), 1'b1, 1'b0);
    step();
    send_row(pe_fill(-3), 12'h021, acc_fill(97), 1'b1, 1'b1);
    pe_out_valid = 1'b1;           // offered during DRAIN: dropped
    pe_out_data  = pe_fill(7);
    step();
    pe_out_valid = 1'b0;
    chk("err_drain_row", RW'(err), RW'(1'b1));
    drain();
    chk("err_held", RW'(err), RW'(1'b1));

    // Address wrap with mixed-sign lanes: lane i of row k = 10k - 7i.
    start_job(12'hFFE, 13'd4, 1'b0);
    chk("err_clear_on_start", RW'(err), '0);
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < N; i++) begin
        d[i*PW +: PW] = PW'(k * 10 - i * 7);
        e[i*DW +: DW] = k * 10 - i * 7;
      end
      send_row(d, wrap_addr[k], e, 1'b0, k == 3);
    end
    drain();

    // Row offered in IDLE: no memory access, err set and sticky.
    pe_out_valid = 1'b1;
    pe_out_data  = pe_fill(5);
    step();
    pe_out_valid = 1'b0;
    step();
    chk("err_idle_row", RW'(err), RW'(1'b1));
    repeat (3) step();
    chk("err_sticky", RW'(err), RW'(1'b1));

    // Zero-row job: done next cycle, no access, stays idle.
    start_job(12'h123, 13'd0, 1'b1);
    chk("zero_rows_idle", RW'(busy), '0);
    drain();

    // Overflow lanes.
    m = acc_fill(32'h7FFFFFFF);
    m[1*DW +: DW] = 32'h80000000;
    m[2*DW +: DW] = 32'h7FFFFFF0;
    m[3*DW +: DW] = 32'h0;
    m[4*DW +: DW] = 32'h0;
    ram[12'h100] = m;
    d = pe_fill(1);
    d[1*PW +: PW] = 19'h7FFFF;     // -1
    d[2*PW +: PW] = 19'h00005;
    d[3*PW +: PW] = 19'h3FFFF;     // largest positive
    d[4*PW +: PW] = 19'h40000;     // most negative
`ifdef ACC_WB_SATURATE_EN
    e = acc_fill(32'h7FFFFFFF);
    e[1*DW +: DW] = 32'h80000000;
`else
    e = acc_fill(32'h80000000);
    e[1*DW +: DW] = 32'h7FFFFFFF;
`endif
    e[2*DW +: DW] = 32'h7FFFFFF5;
    e[3*DW +: DW] = 32'h0003FFFF;
    e[4*DW +: DW] = 32'hFFFC0000;
    start_job(12'h100, 13'd1, 1'b1);
    send_row(d, 12'h100, e, 1'b1, 1'b1);
    drain();

    // Reset after 2 of 4 rows: nothing further is written, no done.
    start_job(12'h200, 13'd4, 1'b0);
    pe_out_valid = 1'b1;
    pe_out_data  = pe_fill(9);
    step();
    step();
    pe_out_valid = 1'b0;
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    chk("abort_busy", RW'(busy), '0);
    chk("abort_state", RW'(state_dbg), RW'(ST_IDLE));
    chk("abort_err", RW'(err), '0);
    repeat (8) step();

    chk("left_writes", RW'(exp_q.size()), '0);
    chk("left_reads", RW'(exp_rd_q.size()), '0);
    chk("left_done", RW'(exp_done_q.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
